// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-family register and bus-driver models.
package ttl_pkg;

  // Mode encoding is {S1,S0}; reused by the LS194/LS323 models.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } ls299_mode_t;

  function automatic ls299_mode_t ls299_mode(input logic s1, input logic s0);
    return ls299_mode_t'({s1, s0});
  endfunction

endpackage

// File: rtl/ttl_tristate.sv
// WIDTH-wide 3-state bus buffer with active-low enable.
module ttl_tristate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             _en,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = _en ? {WIDTH{1'bz}} : data;

endmodule

// File: rtl/ls299.sv
// DM74LS299 universal shift/storage register with 3-state multiplexed I/O.
module ls299
  import ttl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             _CLR,
  input  logic             S0,
  input  logic             S1,
  input  logic             _G1,
  input  logic             _G2,
  input  logic             SR,
  input  logic             SL,
  inout  wire  [WIDTH-1:0] IO,
  output logic             QA_P,
  output logic             QH_P
);

  logic [WIDTH-1:0] q;
  ls299_mode_t      mode;
  logic             oe_n;

  assign mode = ls299_mode(S1, S0);

  // Unknown mode select propagates X into the register for simulation visibility.
  always_ff @(posedge CLK or negedge _CLR) begin
    if (!_CLR) begin
      q <= '0;
    end else begin
      case (mode)
        HOLD:    q <= q;
        SHR:     q <= {q[WIDTH-2:0], SR};
        SHL:     q <= {SL, q[WIDTH-1:1]};
        LOAD:    q <= IO;
        default: q <= 'x;
      endcase
    end
  end

  // Load mode always releases the bus so the external driver can be sampled.
  assign oe_n = _G1 | _G2 | (S0 & S1);

  ttl_tristate #(
    .WIDTH(WIDTH)
  ) u_io_buf (
    .data(q),
    ._en (oe_n),
    .bus (IO)
  );

  assign QA_P = q[0];
  assign QH_P = q[WIDTH-1];

endmodule

// File: tb/tb_ls299.sv
// Directed bench for ls299: clear, load, shifts, output enables, async clear.
`timescale 1ps/1ps
module tb_ls299;

  logic       clk;
  logic       clr_n;
  logic       s0, s1;
  logic       g1_n, g2_n;
  logic       sr, sl;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] io;
  logic       qa, qh;

  int errors = 0;
  int checks = 0;

  // Weak pull-ups make a released bus read as all ones.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (io[i]);
  end

  assign io = drv_en ? drv : 8'bzzzz_zzzz;

  ls299 #(.WIDTH(8)) dut (
    .CLK (clk),
    ._CLR(clr_n),
    .S0  (s0),
    .S1  (s1),
    ._G1 (g1_n),
    ._G2 (g2_n),
    .SR  (sr),
    .SL  (sl),
    .IO  (io),
    .QA_P(qa),
    .QH_P(qh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] shr_exp [8];

  initial begin
    shr_exp = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    clr_n = 1'b0; s0 = 1'b0; s1 = 1'b0; g1_n = 1'b0; g2_n = 1'b0;
    sr = 1'b0; sl = 1'b0; drv = 8'h00; drv_en = 1'b0;

    // Clear with no clock
    #2;
    check("clr_io", io, 8'h00);
    check("clr_qa", {7'd0, qa}, 8'h00);
    check("clr_qh", {7'd0, qh}, 8'h00);

    // Clock a load while clear is held: must be ignored
    s0 = 1'b1; s1 = 1'b1; drv = 8'hFF; drv_en = 1'b1;
    step();
    check("clr_load_qa", {7'd0, qa}, 8'h00);
    check("clr_load_qh", {7'd0, qh}, 8'h00);
    drv_en = 1'b0; s0 = 1'b0; s1 = 1'b0;
    #1;
    check("clr_load_io", io, 8'h00);

    // Load A5 then read back
    clr_n = 1'b1;
    s0 = 1'b1; s1 = 1'b1; drv = 8'hA5; drv_en = 1'b1;
    step();
    drv_en = 1'b0; s0 = 1'b0; s1 = 1'b0;
    #1;
    check("load_io", io, 8'hA5);
    check("load_qa", {7'd0, qa}, 8'h01);
    check("load_qh", {7'd0, qh}, 8'h01);

    // Shift right with SR=0
    s0 = 1'b1; s1 = 1'b0; sr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("shr_%0d", i), io, shr_exp[i]);
      if (i == 0) check("shr_qh_1", {7'd0, qh}, 8'h00);
    end

    // Load 81, shift left with SL=1
    s0 = 1'b1; s1 = 1'b1; drv = 8'h81; drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    s0 = 1'b0; s1 = 1'b1; sl = 1'b1;
    step();
    check("shl_1", io, 8'hC0);
    check("shl_qa_1", {7'd0, qa}, 8'h00);
    step();
    check("shl_2", io, 8'hE0);
    check("shl_qa_2", {7'd0, qa}, 8'h00);

    // Output enables with Q=3C
    s0 = 1'b1; s1 = 1'b1; drv = 8'h3C; drv_en = 1'b1;
    step();
    drv_en = 1'b0; s0 = 1'b0; s1 = 1'b0;
    g1_n = 1'b1;
    #1;
    check("oe_g1", io, 8'hFF);
    check("oe_g1_qa", {7'd0, qa}, 8'h00);
    check("oe_g1_qh", {7'd0, qh}, 8'h00);
    g1_n = 1'b0; g2_n = 1'b1;
    #1;
    check("oe_g2", io, 8'hFF);
    g2_n = 1'b0;
    #1;
    check("oe_both", io, 8'h3C);
    s0 = 1'b1; s1 = 1'b1;
    #1;
    check("oe_loadmode", io, 8'hFF);
    check("oe_loadmode_qa", {7'd0, qa}, 8'h00);
    check("oe_loadmode_qh", {7'd0, qh}, 8'h00);

    // Async clear in the middle of a right shift with SR=1
    s0 = 1'b1; s1 = 1'b0; sr = 1'b1;
    step();
    check("mid_shr", io, 8'h79);
    clr_n = 1'b0;
    #1;
    check("mid_clr", io, 8'h00);
    clr_n = 1'b1;
    #1;
    check("mid_hold_after_clr", io, 8'h00);
    step();
    check("mid_after_clr", io, 8'h01);
    check("mid_after_clr_qa", {7'd0, qa}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
